// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the memory data-port arbiter.
// Holds the response owner encoding, the LED register address and width defaults.
package mem_port_arb_pkg;

    localparam int ADDR_W_DEF = 30;
    localparam int DATA_W_DEF = 32;

    // Word address of the LED register (byte address 0x10003FF0).
    localparam logic [29:0] LED_ADDR = 30'h04000FFC;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

endpackage

// File: rtl/mem_port_arb_rr_arb2.sv
// Two-way round-robin grant with a debug lock and a last-owner register.
// Ports: clk, rst_b, req_c/req_d (requests), lock, gnt_c/gnt_d (same-cycle grants).
module rr_arb2 (
    input  logic clk,
    input  logic rst_b,
    input  logic req_c,
    input  logic req_d,
    input  logic lock,
    output logic gnt_c,
    output logic gnt_d
);

    logic last_d;
    // No grant since reset: the core wins the first contention.
    logic seen;
    logic lock_win;
    logic d_turn;

    always_comb begin
        lock_win = last_d & lock & req_d;
        d_turn   = seen & ~last_d;
        gnt_d    = lock_win | (req_d & (~req_c | d_turn));
        gnt_c    = req_c & ~gnt_d;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            last_d <= 1'b0;
            seen   <= 1'b0;
        end else if (gnt_c | gnt_d) begin
            last_d <= gnt_d;
            seen   <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates core and debug/loader requests onto the single memory data port.
// Ports: c_* core side, d_* debug side, m_* memory side, halted, optional leds
// (present only when MEM_ARB_LED_EN is defined).
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] LED_WADDR = ADDR_W'(LED_ADDR)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                c_req,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_we,
    output logic                c_stall,
    output logic [DATA_W-1:0]   c_rdata,
    output logic                c_excpt,
    input  logic                d_req,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_we,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_excpt,
    input  logic                d_lock,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_we,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_excpt,
    input  logic                halted
`ifdef MEM_ARB_LED_EN
    ,
    output logic [7:0]          leds
`endif
);

    logic              c_act;
    logic              d_act;
    logic              gnt_c;
    logic              gnt_d;
    logic              any_gnt;
    logic [ADDR_W-1:0] addr_q;
    logic              resp_valid;
    logic              resp_owner;
    logic              to_core;
    logic              to_dbg;

    // Requests are masked while reset is asserted so every output sits at
    // its reset value for the whole reset interval.
    assign c_act = c_req & ~halted & rst_b;
    assign d_act = d_req & rst_b;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_b (rst_b),
        .req_c (c_act),
        .req_d (d_act),
        .lock  (d_lock),
        .gnt_c (gnt_c),
        .gnt_d (gnt_d)
    );

    assign any_gnt = gnt_c | gnt_d;
    assign c_stall = c_act & ~gnt_c;
    assign d_gnt   = gnt_d;

    always_comb begin
        m_addr  = addr_q;
        m_wdata = '0;
        m_we    = '0;
        unique case (1'b1)
            gnt_d: begin
                m_addr  = d_addr;
                m_wdata = d_wdata;
                m_we    = d_we;
            end
            gnt_c: begin
                m_addr  = c_addr;
                m_wdata = c_wdata;
                m_we    = c_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            addr_q     <= '0;
            resp_valid <= 1'b0;
            resp_owner <= OWN_CORE;
        end else begin
            resp_valid <= any_gnt;
            resp_owner <= gnt_d ? OWN_DBG : OWN_CORE;
            if (any_gnt) begin
                addr_q <= m_addr;
            end
        end
    end

    assign to_core  = resp_valid & (resp_owner == OWN_CORE);
    assign to_dbg   = resp_valid & (resp_owner == OWN_DBG);
    assign c_rdata  = to_core ? m_rdata : '0;
    assign c_excpt  = to_core & m_excpt;
    assign d_rvalid = to_dbg;
    assign d_rdata  = to_dbg ? m_rdata : '0;
    assign d_excpt  = to_dbg & m_excpt;

`ifdef MEM_ARB_LED_EN
    // The winning write is still forwarded to memory; leds only shadows it.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            leds <= 8'h00;
        end else if (any_gnt && m_addr == LED_WADDR && m_we[0]) begin
            leds <= m_wdata[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: per-cycle reference model plus directed
// scenarios with literal expectations.
module tb_mem_port_arb;
    import mem_port_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        c_req = 1'b0;
    logic [29:0] c_addr = '0;
    logic [31:0] c_wdata = '0;
    logic [3:0]  c_we = '0;
    logic        c_stall;
    logic [31:0] c_rdata;
    logic        c_excpt;
    logic        d_req = 1'b0;
    logic [29:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_we = '0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_excpt;
    logic        d_lock = 1'b0;
    logic [29:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_we;
    logic [31:0] m_rdata = '0;
    logic        m_excpt = 1'b0;
    logic        halted = 1'b0;
`ifdef MEM_ARB_LED_EN
    logic [7:0]  leds;
`endif

    int checks = 0;
    int failures = 0;

    mem_port_arb dut (
        .clk(clk), .rst_b(rst_b),
        .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_we(c_we),
        .c_stall(c_stall), .c_rdata(c_rdata), .c_excpt(c_excpt),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_excpt(d_excpt), .d_lock(d_lock),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
        .m_rdata(m_rdata), .m_excpt(m_excpt), .halted(halted)
`ifdef MEM_ARB_LED_EN
        , .leds(leds)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: who was granted last (0 none, 1 core, 2 debug),
    // who owns the response due this cycle, the last driven address, LEDs.
    int          hist = 0;
    int          pend = 0;
    logic [29:0] last_addr = '0;
    logic [7:0]  led_m = '0;
    logic        mdl_dg = 1'b0;

    always @(negedge clk) begin
        logic ce, cg, dg;
        logic [29:0] ea;
        logic [31:0] ew;
        logic [3:0]  ewe;
        if (!rst_b) begin
            chk("rst_c_stall", c_stall, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_d_rvalid", d_rvalid, 0);
            chk("rst_c_rdata", c_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
            chk("rst_excpt", {c_excpt, d_excpt}, 0);
            chk("rst_m_we", m_we, 0);
            chk("rst_m_addr", m_addr, 0);
`ifdef MEM_ARB_LED_EN
            chk("rst_leds", leds, 0);
`endif
            hist = 0; pend = 0; last_addr = '0; led_m = '0; mdl_dg = 0;
        end else begin
            ce = c_req && !halted;
            if (hist == 2 && d_lock && d_req) dg = 1;
            else if (ce && d_req) dg = (hist == 2) ? 1'b0 : (hist == 1);
            else dg = d_req && !ce;
            cg = ce && !dg;
            mdl_dg = dg;
            ea  = dg ? d_addr : cg ? c_addr : last_addr;
            ew  = dg ? d_wdata : c_wdata;
            ewe = dg ? d_we : cg ? c_we : 4'h0;
            chk("c_stall", c_stall, ce && !cg);
            chk("d_gnt", d_gnt, dg);
            chk("m_addr", m_addr, ea);
            chk("m_we", m_we, ewe);
            if (cg || dg) chk("m_wdata", m_wdata, ew);
            chk("c_rdata", c_rdata, pend == 1 ? m_rdata : 32'h0);
            chk("c_excpt", c_excpt, pend == 1 ? m_excpt : 1'b0);
            chk("d_rvalid", d_rvalid, pend == 2);
            chk("d_rdata", d_rdata, pend == 2 ? m_rdata : 32'h0);
            chk("d_excpt", d_excpt, pend == 2 ? m_excpt : 1'b0);
`ifdef MEM_ARB_LED_EN
            chk("leds", leds, led_m);
`endif
            pend = dg ? 2 : cg ? 1 : 0;
            if (cg || dg) begin
                hist = dg ? 2 : 1;
                last_addr = ea;
                if (ea == LED_ADDR && ewe[0]) led_m = ew[7:0];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        m_rdata = $urandom;
        m_excpt = 1'($urandom_range(0, 1));
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1 rst_b = 1'b0;
        at_neg();
        chk("lit_rst_m_we", m_we, 0);
        chk("lit_rst_m_addr", m_addr, 0);
        chk("lit_rst_d_rvalid", d_rvalid, 0);
        step();
        rst_b = 1'b1;

        // Core-only read.
        step();
        c_req = 1; c_addr = 30'h10; c_we = 0;
        at_neg();
        chk("rd_c_stall", c_stall, 0);
        chk("rd_m_addr", m_addr, 30'h10);
        step();
        c_req = 0; m_rdata = 32'hDEADBEEF; m_excpt = 0;
        at_neg();
        chk("rd_c_rdata", c_rdata, 32'hDEADBEEF);
        chk("rd_d_rvalid", d_rvalid, 0);

        // Contention straight after reset: C,D,C,D.
        step(); rst_b = 0;
        at_neg();
        step(); rst_b = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            c_req = 1; d_req = 1;
            c_addr = 30'h40 + 30'(i); d_addr = 30'h80 + 30'(i);
            at_neg();
            chk("rr_d_gnt", d_gnt, 64'(i % 2));
            chk("rr_c_stall", c_stall, 64'(i % 2));
            chk("rr_model", mdl_dg, 64'(i % 2));
        end

        // Debug burst under lock, after a core-owned cycle.
        step(); d_req = 0; c_addr = 30'h50;
        at_neg();
        for (int i = 0; i < 3; i++) begin
            step();
            d_req = 1; d_lock = 1; d_we = 4'hF;
            d_wdata = 32'h100 + 32'(i); d_addr = 30'h100 + 30'(i);
            at_neg();
            chk("lk_d_gnt", d_gnt, 1);
            chk("lk_c_stall", c_stall, 1);
        end
        step(); d_lock = 0; d_we = 0; c_addr = 30'h20;
        at_neg();
        chk("lk_rel_d_gnt", d_gnt, 0);
        chk("lk_rel_c_stall", c_stall, 0);
        chk("lk_rel_m_addr", m_addr, 30'h20);

        // Halted core write must not reach memory.
        step(); d_req = 0; halted = 1; c_we = 4'hF; c_addr = 30'h30;
        at_neg();
        chk("hlt_m_we", m_we, 0);
        chk("hlt_c_stall", c_stall, 0);
        chk("hlt_m_addr", m_addr, 30'h20);
        step(); halted = 0; c_req = 0; c_we = 0;
        at_neg();

`ifdef MEM_ARB_LED_EN
        step(); c_req = 1; c_addr = LED_ADDR; c_we = 4'b0001;
        c_wdata = 32'h000000A5;
        at_neg();
        step(); c_req = 0; c_we = 0;
        at_neg();
        chk("led_core", leds, 8'hA5);
        step(); d_req = 1; d_addr = LED_ADDR; d_we = 4'b0001;
        d_wdata = 32'h0000003C;
        at_neg();
        step(); d_req = 0; d_we = 0;
        at_neg();
        chk("led_dbg", leds, 8'h3C);
`endif

        // Reset asserted during a debug read grant.
        step(); d_req = 1; d_we = 0; d_addr = 30'h200; c_req = 0;
        at_neg();
        chk("mr_d_gnt", d_gnt, 1);
        rst_b = 0;
        step(); d_req = 0;
        at_neg();
        chk("mr_d_rvalid", d_rvalid, 0);
        step(); rst_b = 1;
        step(); c_req = 1; d_req = 1; c_addr = 30'h60; d_addr = 30'h61;
        at_neg();
        chk("mr_c_first", c_stall, 0);
        chk("mr_d_lose", d_gnt, 0);
        step(); c_req = 0; d_req = 0;
        at_neg();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Two-requester arbiter for the shared data port of the MIPS memory. It multiplexes the core data port and a debug/loader port (UART bootloader, bench backdoor) onto the single read/write port of the memory. It stalls whichever requester loses and routes read data and exceptions back to the owner of each access. It sits between the core/loader and the memory in the top level.

## Interface
- ADDR_W, 30: word-address width.
- DATA_W, 32: data width; byte-enable width is DATA_W/8.
- LED_ADDR, 30'h04000FFC: word address of the LED register (byte address 0x10003FF0).
- clk  in  1  system clock.
- rst_b  in  1  reset, asynchronous, active-low.
- c_req  in  1  core access request; held until granted.
- c_addr  in  ADDR_W  core word address.
- c_wdata  in  DATA_W  core write data.
- c_we  in  DATA_W/8  core byte write enables; all-zero means read.
- c_stall  out  1  core must hold its request this cycle.
- c_rdata  out  DATA_W  read data returned to the core.
- c_excpt  out  1  memory exception for the core's access.
- d_req, d_addr, d_wdata, d_we  in  as above  debug port request.
- d_gnt  out  1  debug access accepted this cycle.
- d_rvalid  out  1  d_rdata/d_excpt valid.
- d_rdata  out  DATA_W; d_excpt  out  1  debug read data and exception.
- d_lock  in  1  while high and debug owns the port, debug keeps the port (burst load).
- m_addr  out  ADDR_W; m_wdata  out  DATA_W; m_we  out  DATA_W/8  memory port drive.
- m_rdata  in  DATA_W; m_excpt  in  1  memory response, one cycle after the address.
- halted  in  1  core halted.
- leds  out  8  LED register (only with MEM_ARB_LED_EN).

## Operation
- Grant is decided combinationally each cycle from c_req, d_req, the last-owner flag `last_d` and the lock state.
- Only one requester pending: it wins.
- Both requesting: the requester not granted last wins (round-robin).
- Lock: if `last_d`=1, d_lock=1 and d_req=1, debug wins regardless of the round-robin rule.
- Core requests are ignored while halted=1. The core gets no grant, and c_stall=0.
- c_stall = c_req & ~halted & ~core_granted. d_gnt = debug_granted.
- The memory port carries the winner's addr/wdata/we. With no grant: m_we=0 and m_addr holds its last value (no spurious writes).
- Response routing: a registered `resp_owner`/`resp_valid` pair records the grant. Next cycle, m_rdata/m_excpt go to the owner.
  - Core: c_rdata and c_excpt.
  - Debug: d_rdata, d_excpt and d_rvalid=1.
- The non-owner's data is 0 and its excpt is 0.
- `last_d` updates only on cycles with a grant.

## Timing
- Grant is same-cycle (combinational). Read latency is 1 cycle after grant. Writes commit at the clock edge of the grant cycle.
- Back-to-back grants are allowed every cycle. Alternating contention gives each requester 50% of cycles.
- Reset values:
  - c_stall=0, d_gnt=0, d_rvalid=0.
  - c_rdata=0, d_rdata=0, c_excpt=0, d_excpt=0.
  - m_we=0, m_addr=0, leds=8'h00.
  - last_d=0, so the core wins the first contention.
- Reset mid-access: response state clears asynchronously. No d_rvalid is produced for an access in flight.
- Simultaneous d_lock rise and core request: lock applies only if debug already owned the previous granted cycle.

## Configuration
- MEM_ARB_LED_EN defined:
  - A granted write to LED_ADDR with we[0]=1, with halted=0 for core writes, loads leds <= wdata[7:0].
  - The write is still forwarded to memory.
- MEM_ARB_LED_EN not defined: the leds port and register are absent, and every write is forwarded unchanged.

## Structure
- The shared package holds:
  - the owner encoding: OWN_CORE=1'b0, OWN_DBG=1'b1;
  - the LED_ADDR constant;
  - the ADDR_W/DATA_W defaults.
- One sub-module, `rr_arb2`: a two-way round-robin grant with lock input and last-owner register. The top handles muxing, response routing and the LED register.

## Test plan
- Core-only read of addr 0x10 with m_rdata=0xDEADBEEF next cycle -> c_stall=0, c_rdata=0xDEADBEEF one cycle after; d_rvalid=0.
- c_req and d_req both held for 4 cycles after reset -> grants alternate C,D,C,D; c_stall high on cycles 2 and 4.
- Debug burst with d_lock=1 for 3 writes while c_req=1 -> debug gets 3 consecutive grants, then the core is granted on the cycle after d_lock falls.
- halted=1 with c_req=1 and c_we=4'hF -> m_we=0, c_stall=0, no memory write.
- With MEM_ARB_LED_EN: core write of 0x000000A5 to LED_ADDR with we=4'b0001 -> leds=0xA5 next cycle. A debug write of 0x3C -> leds=0x3C.
- Assert rst_b low during a debug read grant -> d_rvalid stays 0, all outputs at reset values, and the core wins the first contention after release.
